// File: rtl/bit_stream_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_stream_serializer_if
// Handshake and serial-output bundle for bit_stream_serializer.
//   data_in    : parallel word to serialize (WIDTH bits)
//   data_valid : data_in is valid this cycle
//   data_ready : serializer hold register can accept a word
//   dout       : serial bit toward the sequence detector
//   dout_valid : dout carries a data (or parity) bit
//   busy       : a word is held or being shifted
// Modports: master = upstream producer / observer, slave = serializer.
// -----------------------------------------------------------------------------
interface bit_stream_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  dout,
        input  dout_valid,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output dout,
        output dout_valid,
        output busy
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// -----------------------------------------------------------------------------
// bit_stream_serializer
// Double-buffered parallel-to-serial converter feeding a 1010 sequence
// detector. Words are accepted into a hold register over valid/ready and
// shifted out MSB-first from a shift register, so consecutive words stream
// with no idle bit between them. IDLE_BIT is driven while nothing is in flight.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   ser     : bit_stream_serializer_if.slave (data_in, data_valid, data_ready,
//             dout, dout_valid, busy)
//
// Parameters:
//   WIDTH    : word width, 2..32
//   IDLE_BIT : value on dout when no data bit is sent
//
// Optional feature macro: SER_PARITY_EN
//   When defined, each word is followed by one even-parity bit (XOR of the
//   word), giving a WIDTH+1 cycle word period.
// -----------------------------------------------------------------------------
module bit_stream_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input logic                   clk,
    input logic                   reset_n,
    bit_stream_serializer_if.slave ser
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    // Counter value of the final cycle of a word period.
`ifdef SER_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    typedef enum logic {StIdle, StShift} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q, busy_d;
`ifdef SER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic accept;
    logic last;
    logic xfer;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
`ifdef SER_PARITY_EN
        parity_d     = parity_q;
`endif
        accept       = ser.data_valid && !hold_full_q;
        last         = (state_q == StShift) && (cnt_q == LAST_CNT);
        // Hold drains into the shift register when it is empty or finishing.
        xfer         = hold_full_q && ((state_q == StIdle) || last);

        // data_ready is ~hold_full_q, so accept and xfer never coincide.
        if (accept) begin
            hold_d      = ser.data_in;
            hold_full_d = 1'b1;
        end else if (xfer) begin
            hold_full_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    shift_d = hold_q;
                    cnt_d   = '0;
                    state_d = StShift;
`ifdef SER_PARITY_EN
                    parity_d = ^hold_q;
`endif
                end
            end
            StShift: begin
                if (last) begin
                    cnt_d = '0;
                    if (xfer) begin
                        shift_d = hold_q;
`ifdef SER_PARITY_EN
                        parity_d = ^hold_q;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are computed from next state and registered.
        dout_valid_d = (state_d == StShift);
        dout_d       = IDLE_BIT;
        if (state_d == StShift) begin
            dout_d = shift_d[WIDTH-1];
`ifdef SER_PARITY_EN
            if (cnt_d == CW'(WIDTH)) begin
                dout_d = parity_d;
            end
`endif
        end
        busy_d = (state_d == StShift) | hold_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SER_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
`ifdef SER_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign ser.data_ready = ~hold_full_q;
    assign ser.dout       = dout_q;
    assign ser.dout_valid = dout_valid_q;
    assign ser.busy       = busy_q;

endmodule
